ipv4_hdr_extract: RTL and testbench

//  Sits directly downstream of the per-packet word-strobe state machine in the router output_port_lookup.
//  - Captures Ethernet/IPv4 header fields from the first two 256-bit beats.
//  - Validates the IPv4 header.
//  - Presents one registered result bundle per packet to the lookup/forwarding-decision logic.

---
 rtl/ipv4_hdr_extract.sv | 255 +++++++++++++++++++++++++
 tb/tb_ipv4_hdr_extract.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_hdr_extract.sv
// rtl/ipv4_hdr_extract.sv - Ethernet/IPv4 header field capture and validation
//
// Captures header fields from the first two 256-bit beats of each frame and
// presents one registered result bundle per packet, one cycle after the beat-2
// strobe. Optional build macro: IPV4_CSUM_CHECK_EN builds the header checksum
// pipeline; without it o_csum_ok reports (ipv4 && no options).
//
// Ports:
//   clk, reset (async, active-high)
//   i_tdata            beat data, byte 0 = i_tdata[255:248]
//   i_pkt_word1/2      beat-1 / beat-2 strobes (already tvalid-qualified)
//   i_pkt_is_from_cpu  source flag, sampled with i_pkt_word2
//   o_hdr_valid        one-cycle pulse, bundle below valid
//   o_is_ipv4, o_ver_ok, o_has_options, o_ttl_expired, o_csum_ok, o_from_cpu
//   o_dst_mac, o_ttl, o_proto, o_src_ip, o_dst_ip
module ipv4_hdr_extract #(
    parameter int          C_S_AXIS_DATA_WIDTH = 256,
    parameter logic [15:0] ETHERTYPE_IPV4      = 16'h0800
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] i_tdata,
    input  logic                           i_pkt_word1,
    input  logic                           i_pkt_word2,
    input  logic                           i_pkt_is_from_cpu,
    output logic                           o_hdr_valid,
    output logic                           o_is_ipv4,
    output logic                           o_ver_ok,
    output logic                           o_has_options,
    output logic                           o_ttl_expired,
    output logic                           o_csum_ok,
    output logic                           o_from_cpu,
    output logic [47:0]                    o_dst_mac,
    output logic [7:0]                     o_ttl,
    output logic [7:0]                     o_proto,
    output logic [31:0]                    o_src_ip,
    output logic [31:0]                    o_dst_ip
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_W1 = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Beat-1 capture registers (separate from the output bundle so a new
    // frame can be captured while the previous bundle is being emitted).
    logic [47:0] cap_dst_mac_q, cap_dst_mac_d;
    logic [15:0] cap_eth_type_q, cap_eth_type_d;
    logic [7:0]  cap_ver_ihl_q, cap_ver_ihl_d;
    logic [7:0]  cap_ttl_q, cap_ttl_d;
    logic [7:0]  cap_proto_q, cap_proto_d;
    logic [31:0] cap_src_ip_q, cap_src_ip_d;
    logic [15:0] cap_dst_hi_q, cap_dst_hi_d;

    // Output bundle registers
    logic        hdr_valid_q, hdr_valid_d;
    logic        is_ipv4_q, is_ipv4_d;
    logic        ver_ok_q, ver_ok_d;
    logic        has_options_q, has_options_d;
    logic        ttl_expired_q, ttl_expired_d;
    logic        csum_ok_q, csum_ok_d;
    logic        from_cpu_q, from_cpu_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [7:0]  ttl_q, ttl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;

    logic capture;
    logic finish;
    logic unused_bits;

`ifdef IPV4_CSUM_CHECK_EN
    // Nine halfwords of beat 1 (max 9*0xFFFF) plus one of beat 2 fit 20 bits.
    logic [19:0] cap_csum_sum_q, cap_csum_sum_d;
    logic [19:0] beat1_sum;
    logic [19:0] full_sum;
    logic [16:0] fold1;
    logic [15:0] folded;

    always_comb begin
        beat1_sum = '0;
        for (int i = 0; i < 9; i++) begin
            beat1_sum = beat1_sum + {4'd0, i_tdata[143 - 16*i -: 16]};
        end
        full_sum = cap_csum_sum_q + {4'd0, i_tdata[255:240]};
        fold1    = {1'b0, full_sum[15:0]} + {13'd0, full_sum[19:16]};
        folded   = fold1[15:0] + {15'd0, fold1[16]};
    end

    assign unused_bits = ^i_tdata[207:160];
`else
    assign unused_bits = ^{i_tdata[207:160], i_tdata[135:80], i_tdata[63:48]};
`endif

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        finish         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_pkt_word1) begin
                    capture = 1'b1;
                    state_d = HAVE_W1;
                end
            end
            HAVE_W1: begin
                // word1 wins over word2 if both are seen in the same cycle
                if (i_pkt_word1) begin
                    capture = 1'b1;
                end else if (i_pkt_word2) begin
                    finish  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (i_pkt_word1) begin
                    capture = 1'b1;
                    state_d = HAVE_W1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_dst_mac_d  = cap_dst_mac_q;
        cap_eth_type_d = cap_eth_type_q;
        cap_ver_ihl_d  = cap_ver_ihl_q;
        cap_ttl_d      = cap_ttl_q;
        cap_proto_d    = cap_proto_q;
        cap_src_ip_d   = cap_src_ip_q;
        cap_dst_hi_d   = cap_dst_hi_q;
`ifdef IPV4_CSUM_CHECK_EN
        cap_csum_sum_d = cap_csum_sum_q;
`endif
        if (capture) begin
            cap_dst_mac_d  = i_tdata[255:208];
            cap_eth_type_d = i_tdata[159:144];
            cap_ver_ihl_d  = i_tdata[143:136];
            cap_ttl_d      = i_tdata[79:72];
            cap_proto_d    = i_tdata[71:64];
            cap_src_ip_d   = i_tdata[47:16];
            cap_dst_hi_d   = i_tdata[15:0];
`ifdef IPV4_CSUM_CHECK_EN
            cap_csum_sum_d = beat1_sum;
`endif
        end
    end

    always_comb begin
        hdr_valid_d   = finish;
        is_ipv4_d     = is_ipv4_q;
        ver_ok_d      = ver_ok_q;
        has_options_d = has_options_q;
        ttl_expired_d = ttl_expired_q;
        csum_ok_d     = csum_ok_q;
        from_cpu_d    = from_cpu_q;
        dst_mac_d     = dst_mac_q;
        ttl_d         = ttl_q;
        proto_d       = proto_q;
        src_ip_d      = src_ip_q;
        dst_ip_d      = dst_ip_q;
        if (finish) begin
            is_ipv4_d     = (cap_eth_type_q == ETHERTYPE_IPV4);
            ver_ok_d      = (cap_ver_ihl_q[7:4] == 4'd4) && (cap_ver_ihl_q[3:0] >= 4'd5);
            has_options_d = (cap_ver_ihl_q[3:0] > 4'd5);
            ttl_expired_d = (cap_ttl_q <= 8'd1);
`ifdef IPV4_CSUM_CHECK_EN
            // Only the fixed 20-byte header is summed, so options mean "not checked".
            csum_ok_d     = (folded == 16'hFFFF) && !(cap_ver_ihl_q[3:0] > 4'd5);
`else
            csum_ok_d     = (cap_eth_type_q == ETHERTYPE_IPV4) && !(cap_ver_ihl_q[3:0] > 4'd5);
`endif
            from_cpu_d    = i_pkt_is_from_cpu;
            dst_mac_d     = cap_dst_mac_q;
            ttl_d         = cap_ttl_q;
            proto_d       = cap_proto_q;
            src_ip_d      = cap_src_ip_q;
            dst_ip_d      = {cap_dst_hi_q, i_tdata[255:240]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cap_dst_mac_q  <= '0;
            cap_eth_type_q <= '0;
            cap_ver_ihl_q  <= '0;
            cap_ttl_q      <= '0;
            cap_proto_q    <= '0;
            cap_src_ip_q   <= '0;
            cap_dst_hi_q   <= '0;
`ifdef IPV4_CSUM_CHECK_EN
            cap_csum_sum_q <= '0;
`endif
            hdr_valid_q    <= 1'b0;
            is_ipv4_q      <= 1'b0;
            ver_ok_q       <= 1'b0;
            has_options_q  <= 1'b0;
            ttl_expired_q  <= 1'b0;
            csum_ok_q      <= 1'b0;
            from_cpu_q     <= 1'b0;
            dst_mac_q      <= '0;
            ttl_q          <= '0;
            proto_q        <= '0;
            src_ip_q       <= '0;
            dst_ip_q       <= '0;
        end else begin
            state_q        <= state_d;
            cap_dst_mac_q  <= cap_dst_mac_d;
            cap_eth_type_q <= cap_eth_type_d;
            cap_ver_ihl_q  <= cap_ver_ihl_d;
            cap_ttl_q      <= cap_ttl_d;
            cap_proto_q    <= cap_proto_d;
            cap_src_ip_q   <= cap_src_ip_d;
            cap_dst_hi_q   <= cap_dst_hi_d;
`ifdef IPV4_CSUM_CHECK_EN
            cap_csum_sum_q <= cap_csum_sum_d;
`endif
            hdr_valid_q    <= hdr_valid_d;
            is_ipv4_q      <= is_ipv4_d;
            ver_ok_q       <= ver_ok_d;
            has_options_q  <= has_options_d;
            ttl_expired_q  <= ttl_expired_d;
            csum_ok_q      <= csum_ok_d;
            from_cpu_q     <= from_cpu_d;
            dst_mac_q      <= dst_mac_d;
            ttl_q          <= ttl_d;
            proto_q        <= proto_d;
            src_ip_q       <= src_ip_d;
            dst_ip_q       <= dst_ip_d;
        end
    end

    assign o_hdr_valid   = hdr_valid_q;
    assign o_is_ipv4     = is_ipv4_q;
    assign o_ver_ok      = ver_ok_q;
    assign o_has_options = has_options_q;
    assign o_ttl_expired = ttl_expired_q;
    assign o_csum_ok     = csum_ok_q;
    assign o_from_cpu    = from_cpu_q;
    assign o_dst_mac     = dst_mac_q;
    assign o_ttl         = ttl_q;
    assign o_proto       = proto_q;
    assign o_src_ip      = src_ip_q;
    assign o_dst_ip      = dst_ip_q;

endmodule

// File: tb/tb_ipv4_hdr_extract.sv
// tb/tb_ipv4_hdr_extract.sv - self-checking bench for ipv4_hdr_extract
module tb_ipv4_hdr_extract;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] i_tdata;
    logic         i_pkt_word1;
    logic         i_pkt_word2;
    logic         i_pkt_is_from_cpu;
    logic         o_hdr_valid, o_is_ipv4, o_ver_ok, o_has_options;
    logic         o_ttl_expired, o_csum_ok, o_from_cpu;
    logic [47:0]  o_dst_mac;
    logic [7:0]   o_ttl, o_proto;
    logic [31:0]  o_src_ip, o_dst_ip;

    always #5 clk = ~clk;

    ipv4_hdr_extract dut (
        .clk               (clk),
        .reset             (rst),
        .i_tdata           (i_tdata),
        .i_pkt_word1       (i_pkt_word1),
        .i_pkt_word2       (i_pkt_word2),
        .i_pkt_is_from_cpu (i_pkt_is_from_cpu),
        .o_hdr_valid       (o_hdr_valid),
        .o_is_ipv4         (o_is_ipv4),
        .o_ver_ok          (o_ver_ok),
        .o_has_options     (o_has_options),
        .o_ttl_expired     (o_ttl_expired),
        .o_csum_ok         (o_csum_ok),
        .o_from_cpu        (o_from_cpu),
        .o_dst_mac         (o_dst_mac),
        .o_ttl             (o_ttl),
        .o_proto           (o_proto),
        .o_src_ip          (o_src_ip),
        .o_dst_ip          (o_dst_ip)
    );

    // Stimulus record: frame contents plus hand-derived flag expectations.
    typedef struct {
        logic [47:0]  dst_mac;
        logic [15:0]  etype;
        logic [159:0] hdr;       // IPv4 header, byte 14 of frame in [159:152]
        logic         from_cpu;
        logic         ipv4;
        logic         ver_ok;
        logic         opts;
        logic         ttl_exp;
        logic         csum_on;   // checksum pipeline built
        logic         csum_off;  // checksum pipeline absent
    } vec_t;

    typedef struct {
        logic        fields;     // compare everything beyond o_is_ipv4
        logic        ipv4, ver_ok, opts, ttl_exp, csum, from_cpu;
        logic [47:0] mac;
        logic [7:0]  ttl, proto;
        logic [31:0] src, dst;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulses  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [47:0] mac, input logic [15:0] et,
                                 input logic [159:0] h, input logic fc, input logic ip,
                                 input logic vo, input logic op, input logic te,
                                 input logic con, input logic coff);
        vec_t v;
        v.dst_mac = mac; v.etype = et; v.hdr = h; v.from_cpu = fc;
        v.ipv4 = ip; v.ver_ok = vo; v.opts = op; v.ttl_exp = te;
        v.csum_on = con; v.csum_off = coff;
        return v;
    endfunction

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.fields   = v.ipv4;
        e.ipv4     = v.ipv4;
        e.ver_ok   = v.ver_ok;
        e.opts     = v.opts;
        e.ttl_exp  = v.ttl_exp;
`ifdef IPV4_CSUM_CHECK_EN
        e.csum     = v.csum_on;
`else
        e.csum     = v.csum_off;
`endif
        e.from_cpu = v.from_cpu;
        e.mac      = v.dst_mac;
        e.ttl      = v.hdr[95:88];
        e.proto    = v.hdr[87:80];
        e.src      = v.hdr[63:32];
        e.dst      = v.hdr[31:0];
        return e;
    endfunction

    task automatic send_w1(input vec_t v);
        @(negedge clk);
        i_tdata           = {v.dst_mac, 48'h0a0b0c0d0e0f, v.etype, v.hdr[159:16]};
        i_pkt_word1       = 1'b1;
        i_pkt_word2       = 1'b0;
        i_pkt_is_from_cpu = ~v.from_cpu;
    endtask

    task automatic send_w2(input vec_t v, input bit push);
        logic [255:0] r;
        r = {8{$urandom()}};
        @(negedge clk);
        i_tdata           = {v.hdr[15:0], r[239:0]};
        i_pkt_word1       = 1'b0;
        i_pkt_word2       = 1'b1;
        i_pkt_is_from_cpu = v.from_cpu;
        if (push) sb.push_back(mk_exp(v));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_pkt_word1       = 1'b0;
            i_pkt_word2       = 1'b0;
            i_pkt_is_from_cpu = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && o_hdr_valid) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse expected none");
            end else begin
                e = sb.pop_front();
                chk("is_ipv4", o_is_ipv4, e.ipv4);
                if (e.fields) begin
                    chk("ver_ok",      o_ver_ok,      e.ver_ok);
                    chk("has_options", o_has_options, e.opts);
                    chk("ttl_expired", o_ttl_expired, e.ttl_exp);
                    chk("csum_ok",     o_csum_ok,     e.csum);
                    chk("from_cpu",    o_from_cpu,    e.from_cpu);
                    chk("dst_mac",     o_dst_mac,     e.mac);
                    chk("ttl",         o_ttl,         e.ttl);
                    chk("proto",       o_proto,       e.proto);
                    chk("src_ip",      o_src_ip,      e.src);
                    chk("dst_ip",      o_dst_ip,      e.dst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        //                mac              type      header                                                      cpu ip  vo  op  te  con coff
        vecs[0] = mkv(48'h001122334455, 16'h0800, 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 1'b1, 1, 1, 0, 0, 1, 1);
        vecs[1] = mkv(48'h66778899aabb, 16'h0800, 160'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8_00c7, 1'b0, 1, 1, 0, 0, 0, 1);
        vecs[2] = mkv(48'hffffffffffff, 16'h0800, 160'h4500_0073_0000_4000_0111_b861_c0a8_0001_c0a8_00c7, 1'b1, 1, 1, 0, 1, 0, 1);
        vecs[3] = mkv(48'h010203040506, 16'h0806, 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 1'b0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mkv(48'h0a0a0a0a0a0a, 16'h0800, 160'h4600_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 1'b0, 1, 1, 1, 0, 0, 0);
        vecs[5] = mkv(48'h123456789abc, 16'h0800, 160'h4500_0073_0000_4000_0011_b861_0a00_0001_0a00_0002, 1'b1, 1, 1, 0, 1, 0, 1);
        vecs[6] = mkv(48'hdeadbeef0001, 16'h0800, 160'h4500_0073_0000_4000_0211_f661_c0a8_0001_c0a8_00c7, 1'b0, 1, 1, 0, 0, 1, 1);
        vecs[7] = mkv(48'hcafef00d0002, 16'h0800, 160'h6500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 1'b1, 1, 0, 0, 0, 0, 1);
        vecs[8] = mkv(48'h5a5a5a5a5a5a, 16'h0800, 160'h4400_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 1'b0, 1, 0, 0, 0, 0, 1);

        rst = 1'b1;
        i_tdata = '0;
        i_pkt_word1 = 1'b0;
        i_pkt_word2 = 1'b0;
        i_pkt_is_from_cpu = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid",  o_hdr_valid, 0);
        chk("reset_csum",   o_csum_ok,   0);
        chk("reset_dst_ip", o_dst_ip,    0);
        chk("reset_mac",    o_dst_mac,   0);
        rst = 1'b0;
        idle(2);

        // Table vectors, one frame each
        for (int i = 0; i < 9; i++) begin
            send_w1(vecs[i]);
            send_w2(vecs[i], 1'b1);
            idle(2);
        end
        drain();

        // Outputs hold after the pulse
        idle(4);
        chk("hold_ttl",    o_ttl,       8'h40);
        chk("hold_mac",    o_dst_mac,   48'h5a5a5a5a5a5a);
        chk("hold_novalid", o_hdr_valid, 0);

        // word2 with no prior word1: no pulse
        p0 = pulses;
        send_w2(vecs[0], 1'b0);
        idle(4);
        chk("orphan_word2_pulses", 64'(pulses - p0), 64'd0);

        // word1 twice, then word2: single pulse carrying second header
        p0 = pulses;
        send_w1(vecs[0]);
        send_w1(vecs[2]);
        send_w2(vecs[2], 1'b1);
        idle(3);
        drain();
        chk("double_word1_pulses", 64'(pulses - p0), 64'd1);

        // Back-to-back minimum frames
        p0 = pulses;
        send_w1(vecs[0]);
        send_w2(vecs[0], 1'b1);
        send_w1(vecs[6]);
        send_w2(vecs[6], 1'b1);
        idle(3);
        drain();
        chk("back_to_back_pulses", 64'(pulses - p0), 64'd2);

        // word2 during EMIT is ignored
        p0 = pulses;
        send_w1(vecs[1]);
        send_w2(vecs[1], 1'b1);
        send_w2(vecs[1], 1'b0);
        idle(3);
        drain();
        chk("word2_in_emit_pulses", 64'(pulses - p0), 64'd1);

        // Reset between word1 and word2
        p0 = pulses;
        send_w1(vecs[0]);
        @(negedge clk);
        i_pkt_word1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ttl",    o_ttl,     0);
        chk("midrst_src",    o_src_ip,  0);
        chk("midrst_ipv4",   o_is_ipv4, 0);
        rst = 1'b0;
        send_w2(vecs[0], 1'b0);
        idle(4);
        chk("midrst_pulses", 64'(pulses - p0), 64'd0);
        chk("midrst_dst_ip", o_dst_ip, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
